// File: rtl/tx_data_stage_n_pkg.sv
// Encoder FSM state encoding, link-running decode and default widths
// shared by the TX staging stage.
package tx_data_stage_n_pkg;

    localparam int DATA_W_DEF   = 9;
    localparam int TCODE_W_DEF  = 8;
    localparam int SLOTS_DEF    = 2;
    localparam int CREDIT_W_DEF = 6;
    localparam int STATE_W      = 7;

    typedef enum logic [STATE_W-1:0] {
        START       = 7'b000_0001,
        SEND_NULL   = 7'b000_0010,
        NULL_C      = 7'b000_0100,
        FCT_C       = 7'b000_1000,
        DATA_C      = 7'b001_0000,
        DATA_C_0    = 7'b010_0000,
        TIME_CODE_C = 7'b100_0000
    } tx_state_e;

    // Exact-match decode: an illegal multi-hot state counts as link down.
    function automatic logic link_run(input logic [STATE_W-1:0] state);
        return (state == NULL_C) || (state == FCT_C) || (state == DATA_C) ||
               (state == DATA_C_0) || (state == TIME_CODE_C);
    endfunction

endpackage

// File: rtl/tx_data_stage_n_if.sv
// FIFO-side, credit, encoder-side and time-code signals of the TX staging stage.
// slave is the staging block's view; master is the surrounding driver's view.
interface tx_data_stage_n_if
    import tx_data_stage_n_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int TCODE_W  = TCODE_W_DEF,
    parameter int SLOTS    = SLOTS_DEF,
    parameter int CREDIT_W = CREDIT_W_DEF
);
    localparam int OCC_W = $clog2(SLOTS) + 1;

    logic [STATE_W-1:0]  state_tx;
    logic [DATA_W-1:0]   data_tx_i;
    logic                txwrite_tx;
    logic                txread_tx;
    logic [CREDIT_W-1:0] fct_counter_p;
    logic                credit_dec;
    logic                tickin_tx;
    logic [TCODE_W-1:0]  timecode_tx_i;
    logic [DATA_W-1:0]   tx_data_out;
    logic                data_valid;
    logic                data_ack;
    logic [TCODE_W-1:0]  tx_tcode_out;
    logic                tcode_valid;
    logic                tcode_ack;
    logic                tcode_overrun;
    logic [OCC_W-1:0]    occupancy;

    modport slave (
        input  state_tx, data_tx_i, txwrite_tx, fct_counter_p,
               tickin_tx, timecode_tx_i, data_ack, tcode_ack,
        output txread_tx, credit_dec, tx_data_out, data_valid,
               tx_tcode_out, tcode_valid, tcode_overrun, occupancy
    );

    modport master (
        output state_tx, data_tx_i, txwrite_tx, fct_counter_p,
               tickin_tx, timecode_tx_i, data_ack, tcode_ack,
        input  txread_tx, credit_dec, tx_data_out, data_valid,
               tx_tcode_out, tcode_valid, tcode_overrun, occupancy
    );

endinterface

// File: rtl/tx_data_stage_n_ring.sv
// SLOTS-deep register ring with wrapping pointers and a separate occupancy count.
// Flush returns both pointers to slot 0 and discards the contents.
module tx_stage_ring #(
    parameter int DATA_W = 9,
    parameter int SLOTS  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     load,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata,
    output logic [$clog2(SLOTS):0]   occupancy,
    output logic                     full,
    output logic                     empty
);
    localparam int PTR_W = $clog2(SLOTS);
    localparam int OCC_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [SLOTS];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  occ;
    logic              do_pop;
    logic              do_load;

    assign empty   = (occ == '0);
    assign full    = (occ == OCC_W'(SLOTS));
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot the load needs when full.
    assign do_load = load & (~full | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_load) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_load, do_pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    assign rdata     = mem[rd_ptr];
    assign occupancy = occ;

endmodule

// File: rtl/tx_data_stage_n.sv
// TX staging stage between the host TX FIFO and the SpaceWire encoder:
// credit-gated N-Char ring, pending time-code latch and link-down flush.
module tx_data_stage_n
    import tx_data_stage_n_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int TCODE_W  = TCODE_W_DEF,
    parameter int SLOTS    = SLOTS_DEF,
    parameter int CREDIT_W = CREDIT_W_DEF
) (
    input logic               pclk_tx,
    input logic               reset_tx,
    tx_data_stage_n_if.slave  bus
);
    localparam int OCC_W = $clog2(SLOTS) + 1;

    logic               run;
    logic               pop_ok;
    logic               room_ok;
    logic               credit_ok;
    logic               load;
    logic               inflight;
    logic               ring_full;
    logic               ring_empty;
    logic [DATA_W-1:0]  head_data;
    logic [OCC_W-1:0]   occ;
    logic [TCODE_W-1:0] tcode_q;
    logic               tcode_valid_q;
    logic               tcode_overrun_q;

    assign run     = link_run(bus.state_tx);
    assign pop_ok  = run & bus.data_ack & ~ring_empty;
    assign room_ok = ~ring_full | pop_ok;

    // The credit just spent is not yet visible in fct_counter_p; inflight covers it.
    assign credit_ok = bus.fct_counter_p > CREDIT_W'(inflight);
    assign load      = ~reset_tx & run & bus.txwrite_tx & room_ok & credit_ok;

    always_ff @(posedge pclk_tx or posedge reset_tx) begin
        if (reset_tx) begin
            inflight <= 1'b0;
        end else begin
            inflight <= load;
        end
    end

    tx_stage_ring #(
        .DATA_W (DATA_W),
        .SLOTS  (SLOTS)
    ) u_ring (
        .clk       (pclk_tx),
        .rst       (reset_tx),
        .flush     (~run),
        .load      (load),
        .pop       (pop_ok),
        .wdata     (bus.data_tx_i),
        .rdata     (head_data),
        .occupancy (occ),
        .full      (ring_full),
        .empty     (ring_empty)
    );

    // A tick in the same cycle as the ack replaces the taken code without overrun.
    always_ff @(posedge pclk_tx or posedge reset_tx) begin
        if (reset_tx) begin
            tcode_q         <= '0;
            tcode_valid_q   <= 1'b0;
            tcode_overrun_q <= 1'b0;
        end else if (!run) begin
            tcode_valid_q   <= 1'b0;
            tcode_overrun_q <= 1'b0;
        end else if (bus.tickin_tx) begin
            tcode_q       <= bus.timecode_tx_i;
            tcode_valid_q <= 1'b1;
            if (tcode_valid_q && !bus.tcode_ack) begin
                tcode_overrun_q <= 1'b1;
            end
        end else if (bus.tcode_ack) begin
            tcode_valid_q <= 1'b0;
        end
    end

    assign bus.txread_tx     = load;
    assign bus.credit_dec    = load;
    assign bus.tx_data_out   = head_data;
    assign bus.data_valid    = ~ring_empty;
    assign bus.occupancy     = occ;
    assign bus.tx_tcode_out  = tcode_q;
    assign bus.tcode_valid   = tcode_valid_q;
    assign bus.tcode_overrun = tcode_overrun_q;

endmodule
